// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single word-addressed memory port; grant is combinational, read data returns 1 cycle after grant.
// Losers and non-owners wait with req held; ARB_ROUND_ROBIN_EN selects round-robin over fixed port-0 priority on contention.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t        owner;
  logic          last;
  logic          rd_pend;
  logic          rd_port;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          p0_first;
  logic          gnt0_c;
  logic          gnt1_c;

  // last == 1 means port 1 won most recently, so port 0 is next in turn.
`ifdef ARB_ROUND_ROBIN_EN
  assign p0_first = last;
`else
  assign p0_first = 1'b1 | last;
`endif

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      case (owner)
        OWN_P0:  gnt0_c = m0_req;
        OWN_P1:  gnt1_c = m1_req;
        default: begin
          if (m0_req && (!m1_req || p0_first))
            gnt0_c = 1'b1;
          else if (m1_req)
            gnt1_c = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = gnt0_c | gnt1_c;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (gnt0_c) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt1_c) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_gnt    = gnt0_c;
  assign m1_gnt    = gnt1_c;
  assign m0_rvalid = !rst && rd_pend && !rd_port;
  assign m1_rvalid = !rst && rd_pend && rd_port;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_NONE;
      last    <= 1'b1;
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rd_pend <= mem_en && !mem_we;
      if (mem_en) begin
        rd_port <= gnt1_c;
        last    <= gnt1_c;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      // A lock taken this cycle wins over release of the current owner.
      if (gnt0_c && m0_lock)
        owner <= OWN_P0;
      else if (gnt1_c && m1_lock)
        owner <= OWN_P1;
      else if ((owner == OWN_P0 && !m0_lock) || (owner == OWN_P1 && !m1_lock))
        owner <= OWN_NONE;
    end
  end

endmodule
